// File: rtl/io_intr_ctrl_if.sv
// io_intr_ctrl_if: processor-side cs/rd/wr/rdy register bus for io_intr_ctrl.
interface io_intr_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;
  logic              cs;
  logic              rd;
  logic              wr;
  logic              rdy;
  modport master (output address, in, cs, rd, wr, input out, rdy);
  modport slave (input address, in, cs, rd, wr, output out, rdy);
endinterface

// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: NUM_CH-source interrupt controller with edge/level pending bits,
// fixed-priority vectoring and a wait-stated cs/rd/wr/rdy register port.
module io_intr_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] irq_src,
  io_intr_ctrl_if.slave     bus,
  output logic              intr,
  input  logic              intr_ack
);
  typedef enum logic [1:0] {I_IDLE, I_REQ, I_SVC} irq_st_t;
  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_RDY, B_HOLD} bus_st_t;
  irq_st_t           irq_st_q, irq_st_d;
  bus_st_t           bus_st_q, bus_st_d;
  logic [NUM_CH-1:0] sync_q, src_q, prev_q;
  logic [NUM_CH-1:0] pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
  logic [NUM_CH-1:0] data_q, data_d, pe, w1c;
  logic              vvalid_q, vvalid_d, intr_q, intr_d, rdy_q, rdy_d, wr_q, wr_d;
  logic [4:0]        vidx_q, vidx_d, win;
  logic [1:0]        addr_q, addr_d, raddr;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [31:0]       pend32, rdata;
  logic              idle_bus, accept, fire, rwr, wen, unused_ok;
  assign intr      = intr_q;
  assign bus.rdy   = rdy_q;
  assign bus.out   = out_q;
  assign unused_ok = ^{bus.address[ADDR_W-1:0], bus.in};
  always_comb begin
    pe = pending_q & enable_q;
    pend32 = 32'(pending_q);
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) win = pe[i] ? 5'(i) : win;
    idle_bus = !bus.cs || !(bus.rd || bus.wr);
    accept = bus_st_q == B_IDLE && bus.cs && (bus.rd ^ bus.wr);
    fire = (accept && WAIT_CYC == 0) || (bus_st_q == B_WAIT && bus.cs && cnt_q == 4'd1);
    // with zero wait states the read completes straight from the live bus fields
    raddr = bus_st_q == B_IDLE ? bus.address[3:2] : addr_q;
    rwr = bus_st_q == B_IDLE ? bus.wr : wr_q;
    rdata = raddr == 2'd0 ? pend32 : raddr == 2'd1 ? 32'(enable_q) :
            raddr == 2'd2 ? {vvalid_q, 26'd0, vidx_q} : 32'(edge_q);
    wen = bus_st_q == B_RDY && wr_q;
    w1c = wen && addr_q == 2'd0 ? data_q : '0;
    pending_d = (edge_q & ((pending_q & ~w1c) | (src_q & ~prev_q))) | (~edge_q & src_q);
    enable_d = wen && addr_q == 2'd1 ? data_q : enable_q;
    edge_d = wen && addr_q == 2'd3 ? data_q : edge_q;
    rdy_d = fire;
    out_d = fire && !rwr ? DATA_W'(rdata) : '0;
    addr_d = accept ? bus.address[3:2] : addr_q;
    data_d = accept ? bus.in[NUM_CH-1:0] : data_q;
    wr_d = accept ? bus.wr : wr_q;
    cnt_d = accept ? 4'(WAIT_CYC) : bus_st_q == B_WAIT ? cnt_q - 4'd1 : cnt_q;
    case (bus_st_q)
      B_IDLE:  bus_st_d = accept ? (WAIT_CYC == 0 ? B_RDY : B_WAIT) : B_IDLE;
      B_WAIT:  bus_st_d = !bus.cs ? B_IDLE : cnt_q == 4'd1 ? B_RDY : B_WAIT;
      default: bus_st_d = idle_bus ? B_IDLE : B_HOLD;
    endcase
    irq_st_d = irq_st_q;
    intr_d = intr_q;
    vvalid_d = vvalid_q;
    vidx_d = vidx_q;
    if (irq_st_q == I_IDLE && |pe) begin
      irq_st_d = I_REQ;
      intr_d = 1'b1;
    end else if (irq_st_q == I_REQ && !(|pe)) begin
      irq_st_d = I_IDLE;
      intr_d = 1'b0;
    end else if (irq_st_q == I_REQ && intr_ack) begin
      irq_st_d = I_SVC;
      intr_d = 1'b0;
      vvalid_d = 1'b1;
      vidx_d = win;
    end else if (irq_st_q == I_SVC && !pend32[vidx_q]) begin
      irq_st_d = I_IDLE;
      vvalid_d = 1'b0;
    end
  end
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      irq_st_q  <= I_IDLE;
      bus_st_q  <= B_IDLE;
      sync_q    <= '0;
      src_q     <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      edge_q    <= '0;
      data_q    <= '0;
      vvalid_q  <= 1'b0;
      vidx_q    <= '0;
      intr_q    <= 1'b0;
      rdy_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
    end else begin
      irq_st_q  <= irq_st_d;
      bus_st_q  <= bus_st_d;
      sync_q    <= irq_src;
      src_q     <= sync_q;
      prev_q    <= src_q;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      edge_q    <= edge_d;
      data_q    <= data_d;
      vvalid_q  <= vvalid_d;
      vidx_q    <= vidx_d;
      intr_q    <= intr_d;
      rdy_q     <= rdy_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end
endmodule

// File: tb/tb_io_intr_ctrl.sv
// tb_io_intr_ctrl: directed and random stimulus against a cycle-level behavioural
// model of the interrupt controller, checked with immediate assertions.
module tb_io_intr_ctrl;
  localparam int NCH = 4;
  localparam int WC  = 2;
  logic clk = 1'b0, rst_n = 1'b1, intr, intr_ack = 1'b0;
  logic [NCH-1:0] irq_src = '0;
  int checks = 0, errors = 0;
  bit bus_busy = 1'b0;
  io_intr_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  io_intr_ctrl #(.NUM_CH(NCH), .DATA_W(32), .ADDR_W(32), .WAIT_CYC(WC)) dut (
    .sys_clk(clk), .reset(rst_n), .irq_src(irq_src), .bus(bus), .intr(intr), .intr_ack(intr_ack));
  always #5 clk = ~clk;

  // behavioural model: register contents, interrupt phase and irq sample history
  logic [NCH-1:0] m_pend = '0, m_en = '0, m_edge = '0;
  logic [NCH-1:0] hist[$];
  logic m_valid = 1'b0, m_intr = 1'b0;
  logic [4:0] m_vidx = '0;
  int m_phase = 0;
  logic w_req = 1'b0;
  logic [1:0] w_addr;
  logic [31:0] w_data;

  function automatic logic [31:0] mreg(input logic [1:0] a);
    return a == 2'd0 ? 32'(m_pend) : a == 2'd1 ? 32'(m_en) : a == 2'd2 ? {m_valid, 26'd0, m_vidx} : 32'(m_edge);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [NCH-1:0] pe, s, p, w1c;
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_edge = '0; m_valid = 1'b0; m_vidx = '0; m_intr = 1'b0;
      m_phase = 0; w_req = 1'b0;
      hist.delete();
      repeat (3) hist.push_back('0);
    end else begin
      pe = m_pend & m_en;
      s = hist[1];
      p = hist[2];
      if (m_phase == 0 && pe != 0) begin m_phase = 1; m_intr = 1'b1; end
      else if (m_phase == 1 && pe == 0) begin m_phase = 0; m_intr = 1'b0; end
      else if (m_phase == 1 && intr_ack) begin
        m_phase = 2; m_intr = 1'b0; m_valid = 1'b1;
        m_vidx = 5'($clog2(32'(pe & (~pe + 1'b1))));
      end else if (m_phase == 2 && !m_pend[m_vidx[1:0]]) begin m_phase = 0; m_valid = 1'b0; end
      w1c = (w_req && w_addr == 2'd0) ? w_data[NCH-1:0] : '0;
      for (int i = 0; i < NCH; i++)
        if (!m_edge[i]) m_pend[i] = s[i];
        else if (s[i] && !p[i]) m_pend[i] = 1'b1;
        else if (w1c[i]) m_pend[i] = 1'b0;
      if (w_req && w_addr == 2'd1) m_en = w_data[NCH-1:0];
      if (w_req && w_addr == 2'd3) m_edge = w_data[NCH-1:0];
      w_req = 1'b0;
      hist.push_front(irq_src);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    checks++;
    assert (intr === m_intr) else begin errors++; $error("FAIL intr t=%0t got=%b exp=%b", $time, intr, m_intr); end
    if (!bus_busy) begin
      checks++;
      assert (bus.rdy === 1'b0 && bus.out === 32'h0) else begin
        errors++; $error("FAIL idle_bus t=%0t rdy=%b out=%h exp rdy=0 out=0", $time, bus.rdy, bus.out);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin errors++; $error("FAIL %s got=%h exp=%h", tag, got, exp); end
  endtask

  task automatic access(input logic w, input logic [1:0] a, input logic [31:0] d, input bit both,
                        input bit abort, input bit irq_k1, input logic [NCH-1:0] irq_v, output logic [31:0] got);
    logic [31:0] exp_rd = '0;
    bit ok = !both && !abort;
    bit last;
    got = '0;
    bus_busy = 1'b1;
    bus.cs = 1'b1; bus.rd = !w || both; bus.wr = w || both;
    bus.address = {28'($urandom), a, 2'($urandom)};
    bus.in = d;
    @(posedge clk);
    for (int k = 1; k <= WC + 1; k++) begin
      @(negedge clk);
      last = ok && k == WC + 1;
      chk("rdy", 32'(bus.rdy), 32'(last));
      chk("out", bus.out, (last && !w) ? exp_rd : 32'h0);
      if (k == WC) exp_rd = mreg(a);
      if (last) begin
        got = bus.out;
        if (w) begin w_req = 1'b1; w_addr = a; w_data = d; end
      end
      if (k == 1 && irq_k1) irq_src = irq_v;
      if (k == 1 && abort) bus.cs = 1'b0;
    end
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
    @(negedge clk);
    bus_busy = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] r);
    access(1'b0, a, '0, 1'b0, 1'b0, 1'b0, '0, r);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    access(1'b1, a, d, 1'b0, 1'b0, 1'b0, '0, r);
  endtask

  task automatic wait_intr(input logic v, input string tag);
    int n = 0;
    while (intr !== v && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(intr), 32'(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.address = '0; bus.in = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin rd_reg(2'(a), r); chk("reset_reg", r, 32'h0); end
    // edge channels, fixed priority and re-request after W1C
    wr_reg(2'd1, 32'hF);
    wr_reg(2'd3, 32'hF);
    irq_src = 4'h6;
    @(negedge clk);
    @(negedge clk);
    irq_src = 4'h0;
    @(negedge clk);
    chk("intr_early", 32'(intr), 32'h0);
    @(negedge clk);
    chk("intr_rise", 32'(intr), 32'h1);
    intr_ack = 1'b1; @(negedge clk); intr_ack = 1'b0;
    rd_reg(2'd2, r); chk("vector_ch1", r, 32'h8000_0001);
    wr_reg(2'd0, 32'h2);
    wait_intr(1'b1, "intr_ch2");
    intr_ack = 1'b1; @(negedge clk); intr_ack = 1'b0;
    rd_reg(2'd2, r); chk("vector_ch2", r, 32'h8000_0002);
    wr_reg(2'd0, 32'h4);
    // level channel dropped before ack
    wr_reg(2'd3, 32'h0);
    wr_reg(2'd1, 32'h8);
    irq_src = 4'h8;
    wait_intr(1'b1, "lvl_intr");
    irq_src = 4'h0;
    wait_intr(1'b0, "lvl_drop");
    rd_reg(2'd2, r); chk("lvl_vec_valid", 32'(r[31]), 32'h0); chk("lvl_vec", r, 32'h2);
    // wait-state timing and both-strobe rejection
    wr_reg(2'd1, 32'h5);
    rd_reg(2'd1, r); chk("en_read", r, 32'h5);
    access(1'b0, 2'd1, '0, 1'b1, 1'b0, 1'b0, '0, r);
    // edge arriving on the same edge as its W1C
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd1, 32'h1);
    rd_reg(2'd0, r); chk("pend_before", r, 32'h0);
    access(1'b1, 2'd0, 32'h1, 1'b0, 1'b0, 1'b1, 4'h1, r);
    rd_reg(2'd0, r); chk("set_wins", 32'(r[0]), 32'h1);
    // aborted write leaves ENABLE alone
    access(1'b1, 2'd1, 32'hA, 1'b0, 1'b1, 1'b0, '0, r);
    rd_reg(2'd1, r); chk("abort_en", r, 32'h1);
    // reset in the middle of an access while intr is high
    wait_intr(1'b1, "pre_rst_intr");
    bus_busy = 1'b1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.address = 32'h4;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_intr", 32'(intr), 32'h0);
    chk("rst_rdy", 32'(bus.rdy), 32'h0);
    chk("rst_out", bus.out, 32'h0);
    bus.cs = 1'b0; bus.rd = 1'b0; irq_src = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_busy = 1'b0;
    for (int a = 0; a < 4; a++) begin rd_reg(2'(a), r); chk("post_rst_reg", r, 32'h0); end
    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1: irq_src = NCH'($urandom);
        2: begin intr_ack = 1'b1; @(negedge clk); intr_ack = 1'b0; end
        3: rd_reg(2'($urandom), r);
        4: access(1'b1, 2'($urandom), $urandom, 1'b0, $urandom_range(0, 7) == 0, 1'b0, '0, r);
        default: access(1'b0, 2'($urandom), '0, $urandom_range(0, 5) == 0, 1'b0, 1'b0, '0, r);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_intr_ctrl.md
Name: io_intr_ctrl

Overview:
- Parametrised successor to the single-channel external IO block that sits beside PROCESSOR on the shared ADDRESS/DATA_OUT bus.
- Collects NUM_CH peripheral interrupt sources into per-channel pending bits, each with a selectable edge or level mode and an enable.
- Raises one intr to the processor and latches the granted channel on intr_ack. The channel is chosen by fixed priority, lowest index highest.
- Exposes status and control registers through the cs/rd/wr/rdy handshake, with a configurable number of wait states.

Parameters:
- NUM_CH, 4: number of interrupt sources, 1..32.
- DATA_W, 32: bus data width, at least 32.
- ADDR_W, 32: bus address width.
- WAIT_CYC, 1: extra wait cycles before rdy, 0..15.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- irq_src  in  NUM_CH  raw peripheral requests, asynchronous to sys_clk.
- address  in  ADDR_W  bus address; only address[3:2] is decoded.
- in  in  DATA_W  write data (processor DATA_OUT).
- out  out  DATA_W  read data.
- cs  in  1  chip select.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- rdy  out  1  access-complete pulse.
- intr  out  1  interrupt request to the processor.
- intr_ack  in  1  interrupt acknowledge from the processor.

Behaviour:
- Reset (reset=0, asynchronous):
  - PENDING, ENABLE, EDGE, VECTOR and the synchronisers clear to 0.
  - intr=0, rdy=0, out=0.
  - Both FSMs return to IDLE and any in-flight access is dropped.
- Synchronisation: irq_src passes through a 2-flop synchroniser to give s_src. An edge is s_src=1 with the previous s_src=0.
- Register map, selected by address[3:2]:
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 VECTOR: read-only; bit31 = in-service valid, bits[4:0] = channel index.
  - 3 EDGE: read/write; 1 = edge mode, 0 = level mode.
  - Bits at or above NUM_CH read 0 and ignore writes.
- Pending rules:
  - Edge channel: set on an edge; cleared by a W1C write.
  - Same-cycle edge and W1C on one channel: set wins.
  - Level channel: PENDING[i] = s_src[i] every cycle; W1C has no effect.
- Interrupt FSM:
  - IDLE: if any PENDING&ENABLE bit is set, go to REQ with intr=1 from the next cycle.
  - REQ:
    - intr held at 1.
    - On intr_ack=1: latch the lowest-index set bit of PENDING&ENABLE into VECTOR with bit31=1; go to SVC; intr=0 from the next cycle.
    - If PENDING&ENABLE becomes 0 before ack (level source dropped, or bits disabled or cleared): return to IDLE with intr=0 and VECTOR unchanged.
  - SVC:
    - intr stays 0 and no nesting is allowed.
    - When PENDING[VECTOR] reads 0 (W1C or level source low), clear VECTOR bit31 and go to IDLE.
    - A new request can therefore raise intr no earlier than 2 cycles after the clear.
  - intr_ack outside REQ is ignored.
- Bus FSM:
  - IDLE: accepts an access when cs=1 and exactly one of rd/wr is 1. Both strobes high is ignored, with no rdy.
  - The access then waits WAIT_CYC cycles.
  - rdy=1 for exactly one cycle, WAIT_CYC+1 cycles after acceptance.
  - On that rdy cycle:
    - Read: out carries the register value. out=0 in all other cycles.
    - Write: the register updates at the rising edge that ends the rdy cycle.
  - Address and data are sampled at acceptance.
  - cs=0 during the wait aborts the access: no rdy, no write.
  - cs must drop, or the strobe deassert, before a new access is accepted. The FSM returns to IDLE only after seeing cs=0 or rd=wr=0 (no back-to-back repeats).
- Simultaneous intr_ack and PENDING write: ack arbitration uses PENDING before the write is applied.

Test Plan:
- Reset low mid-access with WAIT_CYC=3 and intr=1 -> the same cycle gives intr=0, rdy=0, out=0; all registers read 0 after release.
- NUM_CH=4: write ENABLE=0xF and EDGE=0xF; pulse irq_src=0x6 -> intr=1 three cycles after the pulse; intr_ack -> VECTOR=0x8000_0001; write PENDING=0x2 -> intr re-asserts for channel 2, VECTOR=0x8000_0002 after ack.
- Level channel 3, EDGE=0x0, ENABLE=0x8: hold irq_src[3]=1 -> intr=1; drop it before ack -> intr=0 and VECTOR bit31=0.
- WAIT_CYC=2: read ENABLE=0x5 -> rdy exactly 3 cycles after the cs/rd cycle, out=0x5 only in the rdy cycle; the same request with rd=wr=1 -> no rdy.
- Edge on channel 0 in the same cycle as a W1C PENDING=0x1 write -> PENDING[0] reads 1 afterwards.
- Drop cs during the wait of a write to ENABLE -> no rdy; ENABLE unchanged.
